if_id_queue: RTL



---
 rtl/if_id_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular FIFO of {pc, inst} pairs between fetch and decode.
// Define IFID_BYPASS_EN to forward fetch straight to decode while the queue is empty.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         branch_interception,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [ADDR_W-1:0]            if_pc,
    input  logic [INST_W-1:0]            if_inst,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [ADDR_W-1:0]            id_pc,
    output logic [INST_W-1:0]            id_inst,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};

    logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
    logic [INST_W-1:0] mem_inst_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
`ifdef IFID_BYPASS_EN
    logic              bypass_s;
`endif

    // Pointers are power-of-two sized, so wrap from DEPTH-1 to 0 is natural overflow.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        ptr_next = ptr + PTR_W'(1);
    endfunction

    // Handshake decode and head presentation.
    always_comb begin
        full_s    = (count_r == FULL_CNT);
        empty_s   = (count_r == EMPTY_CNT);
        if_ready  = !full_s;
        occupancy = count_r;
        id_valid  = 1'b0;
        id_pc     = {ADDR_W{1'b0}};
        id_inst   = {INST_W{1'b0}};
`ifdef IFID_BYPASS_EN
        bypass_s = empty_s && if_valid && !branch_interception;
        if (branch_interception) begin
            id_valid = 1'b0;
        end else if (bypass_s) begin
            id_valid = 1'b1;
            id_pc    = if_pc;
            id_inst  = if_inst;
        end else if (!empty_s) begin
            id_valid = 1'b1;
            id_pc    = mem_pc_r[rd_ptr_r];
            id_inst  = mem_inst_r[rd_ptr_r];
        end else begin
            id_valid = 1'b0;
        end
        // A bypassed pair taken by decode in the same cycle never touches storage.
        push_s = if_valid && !full_s && !branch_interception && !(bypass_s && id_ready);
        pop_s  = !empty_s && id_ready && !branch_interception;
`else
        if (!empty_s) begin
            id_valid = 1'b1;
            id_pc    = mem_pc_r[rd_ptr_r];
            id_inst  = mem_inst_r[rd_ptr_r];
        end else begin
            id_valid = 1'b0;
        end
        push_s = if_valid && !full_s && !branch_interception;
        pop_s  = !empty_s && id_ready && !branch_interception;
`endif
    end

    // Pointer and count update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= EMPTY_CNT;
        end else if (branch_interception) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= EMPTY_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= if_pc;
            mem_inst_r[wr_ptr_r] <= if_inst;
        end
    end

endmodule
